// File: rtl/limit_sched_ctrl.sv
// limit_sched_ctrl: shares one 2-clk float limiter core across CHANNELS controller outputs per solver step.
// Optional core watchdog with pass-through on expiry: define LIMIT_SCHED_TIMEOUT_EN.
module limit_sched_ctrl #(
  parameter int          CHANNELS   = 4,
  parameter int          CH_W       = 2,
  parameter logic [31:0] UPPER_INIT = 32'h3f800000,
  parameter logic [31:0] LOWER_INIT = 32'hbf800000,
  parameter int          TIMEOUT    = 8,
  localparam int         DATA_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sta,
  input  logic [CHANNELS*DATA_W-1:0] x_bus,
  input  logic                       cfg_we,
  input  logic [CH_W-1:0]            cfg_addr,
  input  logic [DATA_W-1:0]          cfg_upper,
  input  logic [DATA_W-1:0]          cfg_lower,
  output logic                       lim_sta,
  output logic [DATA_W-1:0]          lim_x,
  output logic [DATA_W-1:0]          lim_upper,
  output logic [DATA_W-1:0]          lim_lower,
  input  logic [DATA_W-1:0]          lim_y,
  input  logic                       lim_done,
  output logic [CHANNELS*DATA_W-1:0] y_bus,
  output logic                       busy,
  output logic                       done_sig,
  output logic                       err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  state_t                     state;
  logic [CH_W-1:0]            ch;
  logic [CHANNELS*DATA_W-1:0] x_reg;
  logic [DATA_W-1:0]          upper_tab [CHANNELS];
  logic [DATA_W-1:0]          lower_tab [CHANNELS];

  logic [CH_W-1:0]            nxt_ch;
  logic [DATA_W-1:0]          nxt_x;
  logic [DATA_W-1:0]          nxt_upper;
  logic [DATA_W-1:0]          nxt_lower;
  logic                       wd_expire;
  logic                       take_res;
  logic [DATA_W-1:0]          res;

  function automatic logic [DATA_W-1:0] word_of(input logic [CHANNELS*DATA_W-1:0] bus,
                                                input logic [CH_W-1:0]            idx);
    return bus[int'(idx)*DATA_W +: DATA_W];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        upper_tab[i] <= UPPER_INIT;
        lower_tab[i] <= LOWER_INIT;
      end
    end else if (cfg_we) begin
      upper_tab[cfg_addr] <= cfg_upper;
      lower_tab[cfg_addr] <= cfg_lower;
    end
  end

  // Operands for the channel about to be issued; a table write landing on the same edge is forwarded
  // so the limits seen by the core match the table as of the ISSUE cycle.
  always_comb begin
    nxt_ch    = (state == IDLE) ? '0 : ch + 1'b1;
    nxt_x     = word_of((state == IDLE) ? x_bus : x_reg, nxt_ch);
    nxt_upper = (cfg_we && cfg_addr == nxt_ch) ? cfg_upper : upper_tab[nxt_ch];
    nxt_lower = (cfg_we && cfg_addr == nxt_ch) ? cfg_lower : lower_tab[nxt_ch];
    take_res  = (state == WAIT) && (lim_done || wd_expire);
    res       = lim_done ? lim_y : word_of(x_reg, ch);
  end

`ifdef LIMIT_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == WAIT) && !lim_done && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT && !lim_done) ? wd_cnt + 1'b1 : '0;
      if (wd_expire) err <= 1'b1;
    end
  end
`else
  // No watchdog: WAIT holds until the core answers.
  assign wd_expire = (TIMEOUT < 0);
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      x_reg     <= '0;
      y_bus     <= '0;
      lim_sta   <= 1'b0;
      lim_x     <= '0;
      lim_upper <= '0;
      lim_lower <= '0;
      busy      <= 1'b0;
      done_sig  <= 1'b0;
    end else begin
      lim_sta  <= 1'b0;
      done_sig <= 1'b0;
      case (state)
        IDLE: begin
          if (sta) begin
            x_reg     <= x_bus;
            ch        <= '0;
            busy      <= 1'b1;
            lim_sta   <= 1'b1;
            lim_x     <= nxt_x;
            lim_upper <= nxt_upper;
            lim_lower <= nxt_lower;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (take_res) begin
            y_bus[int'(ch)*DATA_W +: DATA_W] <= res;
            if (ch == LAST_CH) begin
              done_sig <= 1'b1;
              state    <= DONE;
            end else begin
              ch        <= nxt_ch;
              lim_sta   <= 1'b1;
              lim_x     <= nxt_x;
              lim_upper <= nxt_upper;
              lim_lower <= nxt_lower;
              state     <= ISSUE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_limit_sched_ctrl.sv
// Bench for limit_sched_ctrl: emulates the 2-clk limiter core and predicts every output from step timing rules.
// Build with LIMIT_SCHED_TIMEOUT_EN defined to include the stuck-core scenario.
module tb_limit_sched_ctrl;
  localparam int CH = 4;
  localparam int TO = 8;

  localparam logic [CH*32-1:0] X1  = {32'h3f800000, 32'h3f000000, 32'hc0400000, 32'h40200000};
  localparam logic [CH*32-1:0] X3  = {32'h40a00000, 32'h40a00000, 32'h40a00000, 32'h40a00000};
  localparam logic [CH*32-1:0] Y1  = {32'h3f800000, 32'h3f000000, 32'hbf800000, 32'h3f800000};
  localparam logic [CH*32-1:0] Y2  = {32'h3f800000, 32'h3f000000, 32'hc0000000, 32'h3f800000};
  localparam logic [CH*32-1:0] Y5A = {32'h3f000000, 32'h3f000000, 32'hbf800000, 32'h3f800000};

  logic          clk = 1'b0, rst = 1'b1, sta = 1'b0, cfg_we = 1'b0, lim_done = 1'b0;
  logic [CH*32-1:0] x_bus = '0;
  logic [1:0]    cfg_addr = '0;
  logic [31:0]   cfg_upper = '0, cfg_lower = '0, lim_y = '0;
  logic          lim_sta, busy, done_sig, err;
  logic [31:0]   lim_x, lim_upper, lim_lower;
  logic [CH*32-1:0] y_bus;

  limit_sched_ctrl dut (
    .clk(clk), .rst(rst), .sta(sta), .x_bus(x_bus),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_upper(cfg_upper), .cfg_lower(cfg_lower),
    .lim_sta(lim_sta), .lim_x(lim_x), .lim_upper(lim_upper), .lim_lower(lim_lower),
    .lim_y(lim_y), .lim_done(lim_done), .y_bus(y_bus),
    .busy(busy), .done_sig(done_sig), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // IEEE single ordering via sign-magnitude key (no NaNs in this bench)
  function automatic logic [31:0] fkey(input logic [31:0] a);
    return a[31] ? ~a : (a | 32'h80000000);
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] x, input logic [31:0] lo, input logic [31:0] up);
    if (fkey(x) > fkey(up)) return up;
    if (fkey(x) < fkey(lo)) return lo;
    return x;
  endfunction

  // Model state
  bit          m_active = 1'b0;
  bit          m_err = 1'b0;
  int          m_t0 = 0;
  int          stuck_ch = -1;
  int          resp_c = -100;
  logic [31:0] resp_v = '0;
  logic [31:0] m_x [CH];
  logic [31:0] m_up [CH];
  logic [31:0] m_lo [CH];
  logic [31:0] m_sup [CH];
  logic [31:0] m_slo [CH];
  logic [CH*32-1:0] m_y = '0;

  function automatic int issue_of(input int k);
    int t;
    t = m_t0 + 1;
    for (int i = 0; i < k; i++) t += 1 + ((i == stuck_ch) ? TO : 2);
    return t;
  endfunction

  function automatic int done_of();
    return issue_of(CH - 1) + 1 + ((CH - 1 == stuck_ch) ? TO : 2);
  endfunction

  int          e_k;
  logic        e_lsta, e_busy, e_done, e_err;
  logic [CH*32-1:0] e_y;

  always @(negedge clk) begin : model
    if (rst) begin
      chk("rst_ctrl", {lim_sta, busy, done_sig, err}, '0);
      chk("rst_ops", {lim_x, lim_upper, lim_lower}, '0);
      chk("rst_y_bus", y_bus, '0);
      m_active = 1'b0;
      m_err    = 1'b0;
      m_y      = '0;
      resp_c   = -100;
      for (int k = 0; k < CH; k++) begin
        m_up[k] = 32'h3f800000;
        m_lo[k] = 32'hbf800000;
      end
    end else begin
      e_k = -1;
      if (m_active)
        for (int k = 0; k < CH; k++)
          if (cyc == issue_of(k)) e_k = k;
      e_lsta = (e_k >= 0);
      e_busy = m_active && (cyc > m_t0);
      e_done = m_active && (cyc == done_of());
      e_err  = m_err || (m_active && stuck_ch >= 0 && cyc >= issue_of(stuck_ch) + TO + 1);
      chk("lim_sta", lim_sta, e_lsta);
      chk("busy", busy, e_busy);
      chk("done_sig", done_sig, e_done);
      chk("err", err, e_err);
      if (e_k >= 0) chk("lim_ops", {lim_x, lim_upper, lim_lower}, {m_x[e_k], m_up[e_k], m_lo[e_k]});
      if (e_done) begin
        for (int k = 0; k < CH; k++)
          e_y[k*32 +: 32] = (k == stuck_ch) ? m_x[k] : clamp(m_x[k], m_slo[k], m_sup[k]);
        chk("y_bus_done", y_bus, e_y);
      end else if (!m_active) begin
        chk("y_bus_hold", y_bus, m_y);
      end
      // core emulation: answer two cycles after each start unless this channel is stuck
      if (lim_sta && !(m_active && e_k >= 0 && e_k == stuck_ch)) begin
        resp_c = cyc + 2;
        resp_v = clamp(lim_x, lim_lower, lim_upper);
      end
      if (e_k >= 0) begin
        m_sup[e_k] = m_up[e_k];
        m_slo[e_k] = m_lo[e_k];
      end
      if (cfg_we) begin
        m_up[cfg_addr] = cfg_upper;
        m_lo[cfg_addr] = cfg_lower;
      end
      if (e_done) begin
        m_y      = e_y;
        m_active = 1'b0;
        if (stuck_ch >= 0) m_err = 1'b1;
      end else if (!m_active && sta) begin
        m_active = 1'b1;
        m_t0     = cyc;
        for (int k = 0; k < CH; k++) m_x[k] = x_bus[k*32 +: 32];
      end
    end
  end

  initial begin : core_drv
    forever begin
      @(posedge clk);
      #1;
      if (!rst && cyc == resp_c) begin
        lim_done = 1'b1;
        lim_y    = resp_v;
      end else begin
        lim_done = 1'b0;
        lim_y    = 32'hdeadbeef;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    sta    = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic start(input logic [CH*32-1:0] x, output int t0);
    next_cycle();
    x_bus = x;
    sta   = 1'b1;
    t0    = cyc;
  endtask

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      next_cycle();
      @(negedge clk);
      if (done_sig === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic cfg(input logic [1:0] a, input logic [31:0] up, input logic [31:0] lo);
    next_cycle();
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_upper = up;
    cfg_lower = lo;
  endtask

  int t0, lat, ndone;

  initial begin : stim
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl_lit", {lim_sta, busy, done_sig, err}, '0);
    chk("reset_y_lit", y_bus, '0);
    next_cycle();
    rst = 1'b0;
    repeat (2) next_cycle();

    // basic step
    start(X1, t0);
    wait_done(t0, lat);
    chk("t1_latency", lat, 13);
    chk("t1_y", y_bus, Y1);
    chk("t1_busy_in_done", busy, 1'b1);

    // reconfigured ch1 limits
    cfg(2'd1, 32'h40400000, 32'hc0000000);
    start(X1, t0);
    wait_done(t0, lat);
    chk("t2_latency", lat, 13);
    chk("t2_y", y_bus, Y2);
    cfg(2'd1, 32'h3f800000, 32'hbf800000);

    // sta while busy and in DONE, with x_bus changed meanwhile
    start(X1, t0);
    ndone = 0;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      if (i == 1) x_bus = X3;
      if (i == 3 || i == 12 || i == 13) sta = 1'b1;
      @(negedge clk);
      if (done_sig === 1'b1) begin
        ndone++;
        chk("t3_latency", cyc - t0, 13);
        chk("t3_y", y_bus, Y1);
      end
    end
    chk("t3_done_count", ndone, 1);

    // reset mid-step
    start(X1, t0);
    for (int i = 1; i <= 6; i++) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_ctrl", {lim_sta, busy, done_sig}, '0);
    chk("t4_rst_y", y_bus, '0);
    next_cycle();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      @(negedge clk);
      if (done_sig === 1'b1) ndone++;
    end
    chk("t4_no_done", ndone, 0);
    start(X1, t0);
    wait_done(t0, lat);
    chk("t4_latency", lat, 13);
    chk("t4_y", y_bus, Y1);

    // limit write timing against ch3's ISSUE (cycle 10)
    start(X1, t0);
    for (int i = 1; i <= 5; i++) next_cycle();
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_upper = 32'h3f000000; cfg_lower = 32'hbf800000;
    wait_done(t0, lat);
    chk("t5a_y", y_bus, Y5A);
    cfg(2'd3, 32'h3f800000, 32'hbf800000);

    start(X1, t0);
    for (int i = 1; i <= 10; i++) next_cycle();
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_upper = 32'h3f000000; cfg_lower = 32'hbf800000;
    wait_done(t0, lat);
    chk("t5b_y", y_bus, Y1);
    cfg(2'd3, 32'h3f800000, 32'hbf800000);

    start(X1, t0);
    for (int i = 1; i <= 9; i++) next_cycle();
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_upper = 32'h3f000000; cfg_lower = 32'hbf800000;
    wait_done(t0, lat);
    chk("t5c_y", y_bus, Y5A);
    cfg(2'd3, 32'h3f800000, 32'hbf800000);

`ifdef LIMIT_SCHED_TIMEOUT_EN
    // core never answers ch2
    stuck_ch = 2;
    start(X1, t0);
    wait_done(t0, lat);
    chk("t6_latency", lat, 19);
    chk("t6_y", y_bus, Y1);
    chk("t6_err", err, 1'b1);
    repeat (2) next_cycle();
    stuck_ch = -1;
    start(X1, t0);
    wait_done(t0, lat);
    chk("t6_after_latency", lat, 13);
    chk("t6_err_sticky", err, 1'b1);
`endif

    repeat (3) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got %0d cycles expected < 20000", cyc);
    $fatal(1);
  end

endmodule
